// File: rtl/key_debounce.sv
// Push-button conditioner: polarity fix, 2-flop synchroniser, debounce FSM, press/release pulses.
// Define LONG_PRESS_EN to add the one-shot key_long pulse after LONG_CYCLES of holding.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned LONG_CYCLES     = 100_000_000,
   parameter bit          KEY_ACTIVE_HIGH = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
      $error("key_debounce: need DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
   end

   typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

   state_e         state_q, state_d;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           sync1_q, key_s_q;
   logic           key_n;
   logic           level_q, level_d;
   logic           press_q, press_d;
   logic           release_q, release_d;
   logic           accept_press, accept_release;

   assign key_n = KEY_ACTIVE_HIGH ? key_in : ~key_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         key_s_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         key_s_q <= sync1_q;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Next state; the counter holds at its terminal value rather than wrapping
   always_comb begin
      state_d        = state_q;
      db_cnt_d       = db_cnt_q;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (key_s_q) begin
               state_d  = StPressWait;
               db_cnt_d = '0;
            end
         end
         StPressWait: begin
            if (!key_s_q) begin
               state_d = StIdle;
            end else if (db_cnt_q == DbLast) begin
               state_d      = StPressed;
               accept_press = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         StPressed: begin
            if (!key_s_q) begin
               state_d  = StReleaseWait;
               db_cnt_d = '0;
            end
         end
         StReleaseWait: begin
            if (key_s_q) begin
               state_d = StPressed;
            end else if (db_cnt_q == DbLast) begin
               state_d        = StIdle;
               accept_release = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered outputs
   always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (accept_press) begin
         level_d = 1'b1;
         press_d = 1'b1;
      end
      if (accept_release) begin
         level_d   = 1'b0;
         release_d = 1'b1;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;

`ifdef LONG_PRESS_EN
   localparam int unsigned    LgW    = $clog2(LONG_CYCLES) + 1;
   localparam logic [LgW-1:0] LgLast = LgW'(LONG_CYCLES - 1);

   logic [LgW-1:0] long_cnt_q, long_cnt_d;
   logic           long_done_q, long_done_d;
   logic           long_q, long_d;
   logic           held;

   assign held = (state_q == StPressed) || (state_q == StReleaseWait);

   always_ff @(posedge clk) begin
      if (rst) begin
         long_cnt_q  <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         long_cnt_q  <= long_cnt_d;
         long_done_q <= long_done_d;
         long_q      <= long_d;
      end
   end

   // long_done keeps a saturated count from firing again until the next accepted press
   always_comb begin
      long_cnt_d  = long_cnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
      if (accept_press) begin
         long_cnt_d  = '0;
         long_done_d = 1'b0;
      end else if (held) begin
         if (long_cnt_q != LgLast) begin
            long_cnt_d = long_cnt_q + 1'b1;
         end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
      end
   end

   assign key_long = long_q;
`else
   assign key_long = 1'b0;
`endif

endmodule
